// File: rtl/lsq_mem_issue_pkg.sv
// Shared types for the load/store issue queue: bus encodings, queue entry
// layout and the issue FSM states.
package lsq_mem_issue_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 5;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MEM_SIZE;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef struct packed {
    logic                 is_store;
    logic                 is_unsigned;
    MEM_SIZE              size;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data;
    logic [ROB_TAG_W-1:0] tag;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } lsq_state_t;

endpackage

// File: rtl/lsq_mem_issue_if.sv
// Dispatch, cache processor-side port and CDB signals of the issue queue.
// master = surrounding pipeline/cache, slave = the queue itself.
interface lsq_mem_issue_if import lsq_mem_issue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int TAG_W = ROB_TAG_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;

  logic             enq_valid;
  logic             enq_ready;
  logic             enq_is_store;
  logic             enq_unsigned;
  MEM_SIZE          enq_size;
  logic [XLEN-1:0]  enq_addr;
  logic [XLEN-1:0]  enq_data;
  logic [TAG_W-1:0] enq_tag;

  logic [XLEN-1:0]  proc2cache_addr;
  logic [XLEN-1:0]  proc2cache_data;
  MEM_SIZE          proc2cache_size;
  BUS_COMMAND       proc2cache_command;
  logic             cache2proc_valid;
  logic [XLEN-1:0]  cache2proc_data;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_is_store;

  logic [CNT_W-1:0] count;

  modport master (
    output flush, enq_valid, enq_is_store, enq_unsigned, enq_size, enq_addr,
           enq_data, enq_tag, cache2proc_valid, cache2proc_data,
    input  enq_ready, proc2cache_addr, proc2cache_data, proc2cache_size,
           proc2cache_command, cdb_valid, cdb_tag, cdb_value, cdb_is_store, count
  );

  modport slave (
    input  flush, enq_valid, enq_is_store, enq_unsigned, enq_size, enq_addr,
           enq_data, enq_tag, cache2proc_valid, cache2proc_data,
    output enq_ready, proc2cache_addr, proc2cache_data, proc2cache_size,
           proc2cache_command, cdb_valid, cdb_tag, cdb_value, cdb_is_store, count
  );

endinterface

// File: rtl/lsq_mem_issue_load_extend.sv
// Combinational load-data sizing and sign/zero extension from the low bits
// of the raw cache word; shared with the store-to-load forwarding path.
module lsq_load_extend import lsq_mem_issue_pkg::*; (
  input  MEM_SIZE         size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] value
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    value = raw;
    case (size)
      BYTE:    value = is_unsigned ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                   : {{(XLEN-8){raw[7]}}, raw[7:0]};
      HALF:    value = is_unsigned ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                   : {{(XLEN-16){raw[15]}}, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/lsq_mem_issue.sv
// In-order load/store issue queue in front of the data cache: circular FIFO,
// one outstanding cache request at a time, completions broadcast on the CDB.
module lsq_mem_issue import lsq_mem_issue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic clk,
  input  logic rst,
  lsq_mem_issue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_state_t       state, state_next;
  lsq_entry_t       entries [DEPTH];
  lsq_entry_t       enq_entry, head_entry;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             do_enq, do_pop;
  logic [XLEN-1:0]  load_value;

  logic             cdb_valid_q, cdb_is_store_q;
  logic [TAG_W-1:0] cdb_tag_q;
  logic [XLEN-1:0]  cdb_value_q;

  // No bypass: a full queue refuses enqueue even when the head pops that cycle.
  assign bus.enq_ready = (count != CNT_W'(DEPTH));
  assign do_enq        = bus.enq_valid && bus.enq_ready && !bus.flush;
  assign do_pop        = (state == REQ) && bus.cache2proc_valid && !bus.flush;
  assign head_entry    = entries[head];

  always_comb begin
    enq_entry = '{is_store:    bus.enq_is_store,
                  is_unsigned: bus.enq_unsigned,
                  size:        bus.enq_size,
                  addr:        bus.enq_addr,
                  data:        bus.enq_data,
                  tag:         ROB_TAG_W'(bus.enq_tag)};
  end

  // NOTE: entry storage has no reset; head/tail/count alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (do_enq) entries[tail] <= enq_entry;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_enq) tail <= tail + 1'b1;
        if (do_pop) head <= head + 1'b1;
        count <= count + CNT_W'(do_enq) - CNT_W'(do_pop);
      end
    end
  end

  // The cache's valid is registered, so IDLE always separates two requests.
  always_comb begin
    state_next             = state;
    bus.proc2cache_command = BUS_NONE;
    bus.proc2cache_addr    = '0;
    bus.proc2cache_data    = '0;
    bus.proc2cache_size    = WORD;
    case (state)
      IDLE: begin
        if (!bus.flush && count != '0) state_next = REQ;
      end
      REQ: begin
        bus.proc2cache_command = head_entry.is_store ? BUS_STORE : BUS_LOAD;
        bus.proc2cache_addr    = head_entry.addr;
        bus.proc2cache_data    = head_entry.data;
        bus.proc2cache_size    = head_entry.size;
        if (bus.flush)                 state_next = bus.cache2proc_valid ? IDLE : DRAIN;
        else if (bus.cache2proc_valid) state_next = IDLE;
      end
      DRAIN: begin
        if (bus.cache2proc_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  lsq_load_extend u_load_extend (
    .size        (head_entry.size),
    .is_unsigned (head_entry.is_unsigned),
    .raw         (bus.cache2proc_data),
    .value       (load_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_value_q    <= '0;
      cdb_is_store_q <= 1'b0;
    end else begin
      cdb_valid_q <= do_pop;
      if (do_pop) begin
        cdb_tag_q      <= TAG_W'(head_entry.tag);
        cdb_value_q    <= head_entry.is_store ? '0 : load_value;
        cdb_is_store_q <= head_entry.is_store;
      end
    end
  end

  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_value    = cdb_value_q;
  assign bus.cdb_is_store = cdb_is_store_q;
  assign bus.count        = count;

endmodule

// File: tb/tb_lsq_mem_issue.sv
// Bench for lsq_mem_issue: directed ops, a registered-valid cache model and a
// CDB scoreboard that compares every completion against hand-computed values.
module tb_lsq_mem_issue;
  import lsq_mem_issue_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 5;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    logic             is_store;
  } cdb_exp_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  cdb_exp_t        sb_q[$];
  logic [XLEN-1:0] resp_q[$];

  bit hold_off   = 1'b0;
  int miss_delay = 0;
  int kick_req   = 0;
  bit gap_en     = 1'b0;

  lsq_mem_issue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  lsq_mem_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offers one op until accepted; expected CDB result goes to the scoreboard.
  task automatic enq_op(input bit st, input bit uns, input MEM_SIZE sz,
                        input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] resp,
                        input logic [XLEN-1:0] exp_val, input bit exp_cdb);
    int n;
    n = 0;
    bus.enq_valid    = 1'b1;
    bus.enq_is_store = st;
    bus.enq_unsigned = uns;
    bus.enq_size     = sz;
    bus.enq_addr     = addr;
    bus.enq_data     = data;
    bus.enq_tag      = tag;
    @(negedge clk);
    while (!bus.enq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("enq_accept", bus.enq_ready, 1);
    if (bus.enq_ready) begin
      if (exp_cdb) sb_q.push_back('{tag: tag, value: exp_val, is_store: st});
      resp_q.push_back(resp);
    end
    cyc();
    bus.enq_valid = 1'b0;
  endtask

  task automatic wait_cmd(input BUS_COMMAND c, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.proc2cache_command != c && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.proc2cache_command, c);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.count != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd"},       bus.proc2cache_command, BUS_NONE);
    check({pfx, "_addr"},      bus.proc2cache_addr, 0);
    check({pfx, "_data"},      bus.proc2cache_data, 0);
    check({pfx, "_size"},      bus.proc2cache_size, WORD);
    check({pfx, "_cdb_valid"}, bus.cdb_valid, 0);
    check({pfx, "_cdb_tag"},   bus.cdb_tag, 0);
    check({pfx, "_cdb_value"}, bus.cdb_value, 0);
    check({pfx, "_cdb_store"}, bus.cdb_is_store, 0);
    check({pfx, "_enq_ready"}, bus.enq_ready, 1);
    check({pfx, "_count"},     bus.count, 0);
  endtask

  // Cache: registered valid one cycle after a REQ cycle is seen, after
  // miss_delay extra REQ cycles; kick_req forces one stray valid.
  initial begin : cache_model
    int wait_cnt;
    int kick_ack;
    bit fire;
    wait_cnt = 0;
    kick_ack = 0;
    bus.cache2proc_valid = 1'b0;
    bus.cache2proc_data  = '0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (kick_req != kick_ack) begin
        fire     = 1'b1;
        kick_ack = kick_req;
      end else if (!hold_off && bus.proc2cache_command != BUS_NONE && !bus.cache2proc_valid) begin
        if (wait_cnt >= miss_delay) fire = 1'b1;
        else wait_cnt++;
      end
      if (fire || bus.proc2cache_command == BUS_NONE) wait_cnt = 0;
      @(posedge clk);
      #1;
      bus.cache2proc_valid = fire;
      bus.cache2proc_data  = (fire && resp_q.size() > 0) ? resp_q.pop_front() : '0;
    end
  end

  initial begin : cdb_monitor
    cdb_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.cdb_valid) begin
        if (sb_q.size() == 0) begin
          check("cdb_unexpected_pulse", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("cdb_tag",      bus.cdb_tag, e.tag);
          check("cdb_value",    bus.cdb_value, e.value);
          check("cdb_is_store", bus.cdb_is_store, e.is_store);
        end
      end
    end
  end

  initial begin : gap_monitor
    int none_run;
    bit seen_req;
    logic [XLEN-1:0] last_addr;
    none_run  = 0;
    seen_req  = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (!gap_en) begin
        none_run = 0;
        seen_req = 1'b0;
      end else if (bus.proc2cache_command == BUS_NONE) begin
        none_run++;
      end else begin
        if (seen_req && none_run > 0) check("bus_none_gap", none_run, 1);
        else if (seen_req && bus.proc2cache_addr != last_addr) check("bus_none_gap", 0, 1);
        seen_req  = 1'b1;
        none_run  = 0;
        last_addr = bus.proc2cache_addr;
      end
    end
  end

  initial begin : main
    rst              = 1'b0;
    bus.flush        = 1'b0;
    bus.enq_valid    = 1'b0;
    bus.enq_is_store = 1'b0;
    bus.enq_unsigned = 1'b0;
    bus.enq_size     = WORD;
    bus.enq_addr     = '0;
    bus.enq_data     = '0;
    bus.enq_tag      = '0;

    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    rst = 1'b1;
    cyc();

    // Load hit: REQ two cycles after enqueue, CDB two cycles after REQ entry.
    enq_op(1'b0, 1'b0, WORD, 32'h100, 32'h0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("hit_idle_cmd", bus.proc2cache_command, BUS_NONE);
    check("hit_count", bus.count, 1);
    @(negedge clk);
    check("hit_req_cmd", bus.proc2cache_command, BUS_LOAD);
    check("hit_req_addr", bus.proc2cache_addr, 32'h100);
    check("hit_req_size", bus.proc2cache_size, WORD);
    @(negedge clk);
    check("hit_req_held", bus.proc2cache_command, BUS_LOAD);
    check("hit_cdb_early", bus.cdb_valid, 0);
    @(negedge clk);
    check("hit_cdb_pulse", bus.cdb_valid, 1);
    check("hit_after_cmd", bus.proc2cache_command, BUS_NONE);
    check("hit_after_count", bus.count, 0);
    @(negedge clk);
    check("hit_cdb_single", bus.cdb_valid, 0);
    cyc();

    // Size and sign extension.
    enq_op(1'b0, 1'b0, BYTE, 32'h104, 32'h0, 5'd4, 32'h00000080, 32'hFFFFFF80, 1'b1);
    enq_op(1'b0, 1'b1, BYTE, 32'h105, 32'h0, 5'd5, 32'h00000080, 32'h00000080, 1'b1);
    enq_op(1'b0, 1'b0, HALF, 32'h106, 32'h0, 5'd6, 32'h0000F00F, 32'hFFFFF00F, 1'b1);
    enq_op(1'b0, 1'b1, HALF, 32'h108, 32'h0, 5'd7, 32'hFFFFF00F, 32'h0000F00F, 1'b1);
    enq_op(1'b0, 1'b0, BYTE, 32'h10C, 32'h0, 5'd2, 32'h1234567F, 32'h0000007F, 1'b1);
    wait_drain("ext_drain");

    // Store miss: request held unchanged while valid is withheld.
    cyc();
    miss_delay = 10;
    enq_op(1'b1, 1'b0, WORD, 32'h200, 32'h55, 5'd1, 32'hFFFFFFFF, 32'h0, 1'b1);
    wait_cmd(BUS_STORE, "miss_req");
    repeat (10) begin
      check("miss_cmd", bus.proc2cache_command, BUS_STORE);
      check("miss_addr", bus.proc2cache_addr, 32'h200);
      check("miss_data", bus.proc2cache_data, 32'h55);
      check("miss_no_cdb", bus.cdb_valid, 0);
      @(negedge clk);
    end
    wait_drain("miss_drain");
    miss_delay = 0;

    // Fill past DEPTH with enq_valid held; pointers wrap while draining.
    cyc();
    miss_delay = 3;
    gap_en     = 1'b1;
    begin
      int  i;
      int  n;
      bit  saw_full;
      bit  st;
      i = 0;
      n = 0;
      saw_full = 1'b0;
      while (i < DEPTH + 3 && n < 300) begin
        st = (i % 3 == 2);
        bus.enq_valid    = 1'b1;
        bus.enq_is_store = st;
        bus.enq_unsigned = 1'b0;
        bus.enq_size     = WORD;
        bus.enq_addr     = 32'h300 + 32'(4 * i);
        bus.enq_data     = 32'hA000 + 32'(i);
        bus.enq_tag      = TAG_W'(8 + i);
        @(negedge clk);
        if (!bus.enq_ready) begin
          saw_full = 1'b1;
          check("full_count", bus.count, DEPTH);
        end else begin
          sb_q.push_back('{tag: TAG_W'(8 + i), value: st ? 32'h0 : 32'h10000000 + 32'(i),
                           is_store: st});
          resp_q.push_back(32'h10000000 + 32'(i));
          i++;
        end
        cyc();
        n++;
      end
      bus.enq_valid = 1'b0;
      check("full_seen", saw_full, 1);
    end
    wait_drain("wrap_drain");
    gap_en     = 1'b0;
    miss_delay = 0;

    // Flush during a miss: DRAIN swallows the late valid, no CDB pulse.
    cyc();
    hold_off = 1'b1;
    enq_op(1'b0, 1'b0, WORD, 32'h400, 32'h0, 5'd20, 32'h0, 32'h0, 1'b0);
    wait_cmd(BUS_LOAD, "fa_req");
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    resp_q.delete();
    resp_q.push_back(32'hBAD0BAD0);
    resp_q.push_back(32'h600D600D);
    sb_q.push_back('{tag: 5'd21, value: 32'h600D600D, is_store: 1'b0});
    bus.enq_valid    = 1'b1;
    bus.enq_is_store = 1'b0;
    bus.enq_size     = WORD;
    bus.enq_addr     = 32'h500;
    bus.enq_tag      = 5'd21;
    @(negedge clk);
    check("fa_drain_cmd", bus.proc2cache_command, BUS_NONE);
    check("fa_count", bus.count, 0);
    check("fa_no_cdb", bus.cdb_valid, 0);
    cyc();
    bus.enq_valid = 1'b0;
    kick_req++;
    hold_off = 1'b0;
    @(negedge clk);
    check("fa_drain_hold", bus.proc2cache_command, BUS_NONE);
    wait_drain("fa_next_op");

    // Flush in the same cycle as valid: response dropped, back to IDLE.
    cyc();
    enq_op(1'b0, 1'b0, WORD, 32'h700, 32'h0, 5'd22, 32'hCAFE0000, 32'h0, 1'b0);
    wait_cmd(BUS_LOAD, "fb_req");
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    check("fb_no_cdb", bus.cdb_valid, 0);
    check("fb_cmd", bus.proc2cache_command, BUS_NONE);
    check("fb_count", bus.count, 0);
    cyc();
    enq_op(1'b0, 1'b0, WORD, 32'h704, 32'h0, 5'd23, 32'h13579BDF, 32'h13579BDF, 1'b1);
    wait_drain("fb_next_op");

    // Reset in the middle of a miss.
    cyc();
    hold_off = 1'b1;
    enq_op(1'b1, 1'b0, WORD, 32'h800, 32'h77, 5'd24, 32'h0, 32'h0, 1'b0);
    wait_cmd(BUS_STORE, "rst_req");
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    resp_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    hold_off = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_abandon", bus.proc2cache_command, BUS_NONE);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsq_mem_issue.md
# lsq_mem_issue

In-order load/store issue queue sitting directly upstream of the data cache. Accepts memory ops from the load/store reservation stations and holds them in a circular FIFO. Presents one request at a time on the cache's processor-side port, holding it until the cache signals valid. Broadcasts the completed result with its ROB tag on the CDB.

## Interface
- DEPTH, 8: queue entries (power of two, ≥2)
- TAG_W, 5: ROB tag width
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  squash all queued and in-flight ops (branch mispredict)
- enq_valid  in  1  dispatch offers an op
- enq_ready  out  1  queue can accept; `count < DEPTH`
- enq_is_store  in  1  1 = store, 0 = load
- enq_unsigned  in  1  load zero-extends (LBU/LHU)
- enq_size  in  MEM_SIZE  BYTE/HALF/WORD
- enq_addr  in  XLEN  effective address
- enq_data  in  XLEN  store data
- enq_tag  in  TAG_W  ROB tag
- proc2cache_addr  out  XLEN  head address while in REQ, else 0
- proc2cache_data  out  XLEN  head store data while in REQ, else 0
- proc2cache_size  out  MEM_SIZE  head size
- proc2cache_command  out  BUS_COMMAND  BUS_LOAD/BUS_STORE in REQ, BUS_NONE otherwise
- cache2proc_valid  in  1  cache completion
- cache2proc_data  in  XLEN  load data (raw word)
- cdb_valid  out  1  one-cycle completion pulse
- cdb_tag  out  TAG_W  ROB tag of completed op
- cdb_value  out  XLEN  extended load value; 0 for stores
- cdb_is_store  out  1  completed op was a store
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- FIFO: head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is tracked separately.
- Enqueue writes at tail when `enq_valid && enq_ready`. There is no bypass: when full, a pop in the same cycle does not free a slot for enqueue.
- The state machine has three states.
  - IDLE: drive BUS_NONE and ignore `cache2proc_valid`. If `count != 0` → REQ.
  - REQ: drive the head entry on proc2cache_* every cycle. A miss (valid low) keeps the FSM in REQ with the request held unchanged. On `cache2proc_valid`: pop head, register the CDB outputs, → IDLE.
  - DRAIN: drive BUS_NONE and wait for the stale `cache2proc_valid`, discarding it, → IDLE.
- Mandatory BUS_NONE gap: the FSM always passes through IDLE for ≥1 cycle between requests, because the cache's valid is registered and would otherwise alias onto the next request.
- Load extension, from the low bits of `cache2proc_data`:
  - BYTE uses [7:0] and HALF uses [15:0].
  - Sign- or zero-extend per `enq_unsigned`.
  - WORD passes through.
- Stores complete on the CDB with value 0 and `cdb_is_store = 1`.
- Flush takes effect next cycle:
  - Head, tail and count are cleared to 0.
  - Flush wins over a simultaneous enqueue; the enqueue is dropped.
  - Flush in REQ without valid → DRAIN.
  - Flush in REQ with valid in the same cycle → response discarded, no CDB pulse, → IDLE.
  - Flush in IDLE or DRAIN → state unchanged.
  - The CDB register is not written on a flushed completion.

## Timing
- Reset (`rst == 0` at posedge) puts outputs in this state:
  - FSM = IDLE; head = tail = count = 0.
  - `proc2cache_command = BUS_NONE`; proc2cache_addr/data = 0; proc2cache_size = WORD.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_is_store = 0; `enq_ready = 1`.
- Reset mid-request abandons the in-flight op with no DRAIN; the cache is reset alongside.
- Enqueue at cycle t into an empty queue: REQ at t+2, request visible on the port from t+2.
- Cache hit at REQ cycle r (valid at r+1): cdb_valid at r+2. The next request appears no earlier than r+3.
- Best-case throughput: one op per 3 cycles. A miss adds cycles only while valid is low.
- proc2cache_* are Moore outputs of the FSM and head entry. proc2cache_data is stable throughout REQ.

## Structure
- The shared package (with `XLEN`, `MEM_SIZE`, `BUS_COMMAND`) holds:
  - `lsq_entry_t` (is_store, unsigned, size, addr, data, tag);
  - `lsq_state_t` enum {IDLE, REQ, DRAIN}.
- One sub-module, `lsq_load_extend`: combinational size/sign extension, reused by the later forwarding path.
- Entry storage is a plain register array in the top.

## Test plan
- Load hit: enqueue LW tag 3, addr 0x100; cache returns 0xDEADBEEF one cycle after REQ → cdb_valid pulses once with tag 3, value 0xDEADBEEF, 2 cycles after REQ entry.
- Extension: LB addr 0x104 on data 0x00000080 → cdb_value 0xFFFFFF80. LBU → 0x00000080. LH on 0x0000F00F → 0xFFFFF00F.
- Miss hold: store tag 1, addr 0x200, data 0x55; valid withheld 10 cycles → request stable all 10 cycles, then one CDB pulse with is_store = 1 and value 0.
- Full and wrap: enqueue DEPTH+3 ops with enq_valid held → enq_ready drops at count = DEPTH. All ops complete in enqueue order across pointer wrap. Exactly one BUS_NONE cycle separates consecutive requests.
- Flush, in two cases:
  - During REQ with valid low: FSM → DRAIN, late valid discarded, no CDB pulse, count = 0.
  - In the same cycle as valid: no CDB pulse, FSM → IDLE.
- Reset mid-miss: `rst` low for 1 cycle during REQ → all outputs at reset values next cycle, enq_ready = 1.
